multicycle_ctrl: RTL and testbench

//   FSM that sequences the shared single-memory datapath over multiple cycles: FETCH, DECODE, EXEC, MEM, WB.

---
 rtl/multicycle_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a shared single-memory multicycle datapath. It sequences
//   FETCH, DECODE, EXEC, MEM and WB for four instruction classes (R-type, load,
//   store, branch) and drives the datapath control strobes.
//   A memory access in FETCH or MEM that gets no mem_ack for MEM_TIMEOUT
//   cycles sends the FSM to a sticky ERR state, which only rst leaves.
//   The FSM also keeps a count of retired instructions.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | stopped, waiting for run
//   FETCH | instruction read at PC; on mem_ack load IR and PC+4
//   DECODE| capture op
//   EXEC  | ALU operation; a branch retires here
//   MEM   | data access at ALU result; a store retires on mem_ack
//   WB    | register file write; retires
//   ERR   | memory timeout; sticky until rst
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   run                 keep sequencing instructions (0 = stop after retire)
//   op                  opcode, sampled in DECODE
//   zero                ALU zero flag, used by a branch in EXEC
//   mem_ack             memory access done this cycle (FETCH/MEM only)
//   IorD .. AluOp       datapath control strobes (combinational)
//   busy, err, state    status and debug
//   instr_count         retired-instruction count, wraps
module multicycle_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             run,
   input  logic [1:0]       op,
   input  logic             zero,
   input  logic             mem_ack,
   output logic             IorD,
   output logic             IrWrite,
   output logic             PcWrite,
   output logic             RegDst,
   output logic             RegWrite,
   output logic             AluSrc,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic [1:0]       AluOp,
   output logic             busy,
   output logic             err,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

   localparam logic [1:0] OP_R     = 2'b00;
   localparam logic [1:0] OP_LOAD  = 2'b01;
   localparam logic [1:0] OP_STORE = 2'b10;
   localparam logic [1:0] OP_BR    = 2'b11;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_UNUSED = 3'd6,
      S_ERR    = 3'd7
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d, wait_inc;
   logic [CNT_W-1:0]   instr_count_q, instr_count_d;
   logic               retire;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         op_q          <= OP_R;
         wait_cnt_q    <= '0;
         instr_count_q <= '0;
      end else begin
         state_q       <= state_d;
         op_q          <= op_d;
         wait_cnt_q    <= wait_cnt_d;
         instr_count_q <= instr_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      wait_cnt_d    = wait_cnt_q;
      instr_count_d = instr_count_q;
      retire        = 1'b0;
      wait_inc      = wait_cnt_q + 1'b1;

      case (state_q)
         S_IDLE: if (run) state_d = S_FETCH;
         S_FETCH: begin
            // An ack in the limit cycle still completes the access.
            if (mem_ack)                                state_d = S_DECODE;
            else if (wait_inc == WAIT_W'(MEM_TIMEOUT))  state_d = S_ERR;
            else                                        wait_cnt_d = wait_inc;
         end
         S_DECODE: begin
            op_d    = op;
            state_d = S_EXEC;
         end
         S_EXEC: begin
            case (op_q)
               OP_R:    state_d = S_WB;
               OP_BR:   retire  = 1'b1;
               default: state_d = S_MEM;
            endcase
         end
         S_MEM: begin
            if (mem_ack) begin
               if (op_q == OP_LOAD) state_d = S_WB;
               else                 retire  = 1'b1;
            end else if (wait_inc == WAIT_W'(MEM_TIMEOUT)) begin
               state_d = S_ERR;
            end else begin
               wait_cnt_d = wait_inc;
            end
         end
         S_WB:  retire  = 1'b1;
         S_ERR: state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase

      if (retire) begin
         instr_count_d = instr_count_q + 1'b1;
         state_d       = run ? S_FETCH : S_IDLE;
      end

      // Each access gets a fresh timeout budget.
      if (state_d != state_q) wait_cnt_d = '0;
   end

   always_comb begin
      IorD     = 1'b0;
      IrWrite  = 1'b0;
      PcWrite  = 1'b0;
      RegDst   = 1'b0;
      RegWrite = 1'b0;
      AluSrc   = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      MemtoReg = 1'b0;
      AluOp    = 2'b00;
      busy     = 1'b0;
      err      = 1'b0;

      case (state_q)
         S_FETCH: begin
            busy    = 1'b1;
            MemRead = 1'b1;
            IrWrite = mem_ack;
            PcWrite = mem_ack;
         end
         S_DECODE: busy = 1'b1;
         S_EXEC: begin
            busy = 1'b1;
            case (op_q)
               OP_R:    AluOp = 2'b10;
               OP_BR: begin
                  AluOp   = 2'b01;
                  PcWrite = zero;
               end
               default: AluSrc = 1'b1;
            endcase
         end
         S_MEM: begin
            busy   = 1'b1;
            IorD   = 1'b1;
            AluSrc = 1'b1;
            if (op_q == OP_LOAD) MemRead  = 1'b1;
            else                 MemWrite = 1'b1;
         end
         S_WB: begin
            busy     = 1'b1;
            RegWrite = 1'b1;
            if (op_q == OP_LOAD) MemtoReg = 1'b1;
            else                 RegDst   = 1'b1;
         end
         S_ERR: err = 1'b1;
         default: ;
      endcase
   end

   assign state       = state_q;
   assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl. Each driven cycle pushes the expected output
// vector and count; a monitor pops and compares on the falling edge.
// A second instance with CNT_W=2 shares the inputs to exercise count wrap.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [1:0]  op = 2'b00;
   logic        zero = 1'b0;
   logic        mem_ack = 1'b0;

   logic        IorD, IrWrite, PcWrite, RegDst, RegWrite, AluSrc;
   logic        MemRead, MemWrite, MemtoReg, busy, err;
   logic [1:0]  AluOp;
   logic [2:0]  state;
   logic [15:0] instr_count;

   logic        w_IorD, w_IrWrite, w_PcWrite, w_RegDst, w_RegWrite, w_AluSrc;
   logic        w_MemRead, w_MemWrite, w_MemtoReg, w_busy, w_err;
   logic [1:0]  w_AluOp;
   logic [2:0]  w_state;
   logic [1:0]  w_count;

   always #5 clk = ~clk;

   multicycle_ctrl #(.CNT_W(16), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst), .run(run), .op(op), .zero(zero), .mem_ack(mem_ack),
      .IorD(IorD), .IrWrite(IrWrite), .PcWrite(PcWrite), .RegDst(RegDst),
      .RegWrite(RegWrite), .AluSrc(AluSrc), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .AluOp(AluOp), .busy(busy), .err(err), .state(state),
      .instr_count(instr_count)
   );

   multicycle_ctrl #(.CNT_W(2), .MEM_TIMEOUT(15)) dut_wrap (
      .clk(clk), .rst(rst), .run(run), .op(op), .zero(zero), .mem_ack(mem_ack),
      .IorD(w_IorD), .IrWrite(w_IrWrite), .PcWrite(w_PcWrite), .RegDst(w_RegDst),
      .RegWrite(w_RegWrite), .AluSrc(w_AluSrc), .MemRead(w_MemRead),
      .MemWrite(w_MemWrite), .MemtoReg(w_MemtoReg), .AluOp(w_AluOp), .busy(w_busy),
      .err(w_err), .state(w_state), .instr_count(w_count)
   );

   // Bit order: IorD IrWrite PcWrite RegDst RegWrite AluSrc MemRead MemWrite
   //            MemtoReg AluOp[1:0] busy err state[2:0]
   localparam logic [15:0] E_IDLE   = 16'b0_0_0_0_0_0_0_0_0_00_0_0_000;
   localparam logic [15:0] E_F_WT   = 16'b0_0_0_0_0_0_1_0_0_00_1_0_001;
   localparam logic [15:0] E_F_ACK  = 16'b0_1_1_0_0_0_1_0_0_00_1_0_001;
   localparam logic [15:0] E_DEC    = 16'b0_0_0_0_0_0_0_0_0_00_1_0_010;
   localparam logic [15:0] E_EX_R   = 16'b0_0_0_0_0_0_0_0_0_10_1_0_011;
   localparam logic [15:0] E_EX_LS  = 16'b0_0_0_0_0_1_0_0_0_00_1_0_011;
   localparam logic [15:0] E_EX_BZ  = 16'b0_0_1_0_0_0_0_0_0_01_1_0_011;
   localparam logic [15:0] E_EX_BN  = 16'b0_0_0_0_0_0_0_0_0_01_1_0_011;
   localparam logic [15:0] E_MEM_LD = 16'b1_0_0_0_0_1_1_0_0_00_1_0_100;
   localparam logic [15:0] E_MEM_ST = 16'b1_0_0_0_0_1_0_1_0_00_1_0_100;
   localparam logic [15:0] E_WB_R   = 16'b0_0_0_1_1_0_0_0_0_00_1_0_101;
   localparam logic [15:0] E_WB_LD  = 16'b0_0_0_0_1_0_0_0_1_00_1_0_101;
   localparam logic [15:0] E_ERR    = 16'b0_0_0_0_0_0_0_0_0_00_0_1_111;

   typedef struct {
      logic [15:0] vec;
      logic [15:0] cnt;
      string       name;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] exp_cnt = '0;
   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc_no = 0;

   task automatic cyc(input logic r, input logic rn, input logic [1:0] o,
                      input logic z, input logic a, input logic [15:0] ev,
                      input bit ret, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; run = rn; op = o; zero = z; mem_ack = a;
      if (r) exp_cnt = '0;
      e.vec  = ev;
      e.cnt  = exp_cnt;
      e.name = nm;
      sb_q.push_back(e);
      if (ret) exp_cnt = exp_cnt + 16'd1;
   endtask

   task automatic fetch_dec(input logic rn, input logic [1:0] o);
      cyc(0, rn, o, 1'b0, 1'b1, E_F_ACK, 0, "fetch");
      cyc(0, rn, o, 1'b0, 1'b0, E_DEC,   0, "decode");
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t        e;
      logic [15:0] act;
      forever begin
         @(negedge clk);
         cyc_no++;
         if (sb_q.size() != 0) begin
            e   = sb_q.pop_front();
            act = {IorD, IrWrite, PcWrite, RegDst, RegWrite, AluSrc, MemRead,
                   MemWrite, MemtoReg, AluOp, busy, err, state};
            n_checks++;
            if (act !== e.vec) begin
               n_errors++;
               $display("FAIL %s outputs cycle %0d: got %b expected %b",
                        e.name, cyc_no, act, e.vec);
            end
            n_checks++;
            if (instr_count !== e.cnt) begin
               n_errors++;
               $display("FAIL %s instr_count cycle %0d: got %0d expected %0d",
                        e.name, cyc_no, instr_count, e.cnt);
            end
            n_checks++;
            if (w_count !== e.cnt[1:0]) begin
               n_errors++;
               $display("FAIL %s wrap_count cycle %0d: got %0d expected %0d",
                        e.name, cyc_no, w_count, e.cnt[1:0]);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, queue %0d entries left", sb_q.size());
      $fatal(1, "watchdog");
   end

   initial begin
      // reset, then start; ack in IDLE is ignored
      cyc(1, 0, 2'b00, 0, 0, E_IDLE, 0, "reset");
      cyc(0, 1, 2'b00, 0, 1, E_IDLE, 0, "idle_go");

      // R-type, zero-wait: 4 cycles
      fetch_dec(1, 2'b00);
      cyc(0, 1, 2'b00, 0, 1, E_EX_R, 0, "r_exec");
      cyc(0, 1, 2'b00, 0, 1, E_WB_R, 1, "r_wb");

      // load with 3 wait cycles in MEM; op changed after DECODE is ignored
      fetch_dec(1, 2'b01);
      cyc(0, 1, 2'b11, 0, 0, E_EX_LS, 0, "ld_exec");
      for (int i = 0; i < 3; i++) cyc(0, 1, 2'b11, 0, 0, E_MEM_LD, 0, "ld_mem_wait");
      cyc(0, 1, 2'b11, 0, 1, E_MEM_LD, 0, "ld_mem_ack");
      cyc(0, 1, 2'b11, 0, 0, E_WB_LD, 1, "ld_wb");

      // branch taken / not taken
      fetch_dec(1, 2'b11);
      cyc(0, 1, 2'b00, 1, 0, E_EX_BZ, 1, "br_taken");
      fetch_dec(1, 2'b11);
      cyc(0, 1, 2'b00, 0, 0, E_EX_BN, 1, "br_not_taken");

      // store with run dropped in EXEC, then IDLE
      fetch_dec(1, 2'b10);
      cyc(0, 0, 2'b10, 0, 0, E_EX_LS, 0, "st_exec");
      cyc(0, 0, 2'b10, 0, 1, E_MEM_ST, 1, "st_mem");
      cyc(0, 0, 2'b10, 0, 0, E_IDLE, 0, "st_idle");
      cyc(0, 0, 2'b10, 0, 1, E_IDLE, 0, "idle_hold");

      // ack on the last allowed FETCH cycle completes the access
      cyc(0, 1, 2'b00, 0, 0, E_IDLE, 0, "idle_go2");
      for (int i = 0; i < 14; i++) cyc(0, 1, 2'b00, 0, 0, E_F_WT, 0, "fetch_wait");
      cyc(0, 1, 2'b00, 0, 1, E_F_ACK, 0, "fetch_last_ack");
      cyc(0, 1, 2'b00, 0, 0, E_DEC, 0, "decode_after_wait");
      cyc(0, 1, 2'b00, 0, 0, E_EX_R, 0, "r_exec2");
      cyc(0, 1, 2'b00, 0, 0, E_WB_R, 1, "r_wb2");

      // full timeout in FETCH -> sticky ERR, count holds
      for (int i = 0; i < 15; i++) cyc(0, 1, 2'b00, 0, 0, E_F_WT, 0, "fetch_timeout");
      for (int i = 0; i < 3; i++)  cyc(0, 1, 2'b00, 0, 1, E_ERR, 0, "err_sticky");
      cyc(1, 1, 2'b00, 0, 1, E_IDLE, 0, "rst_err");

      // five taken branches, then async reset in MEM
      cyc(0, 1, 2'b00, 0, 0, E_IDLE, 0, "idle_go3");
      for (int i = 0; i < 5; i++) begin
         fetch_dec(1, 2'b11);
         cyc(0, 1, 2'b11, 1, 0, E_EX_BZ, 1, "br_count");
      end
      fetch_dec(1, 2'b01);
      cyc(0, 1, 2'b01, 0, 0, E_EX_LS, 0, "ld_exec2");
      cyc(0, 1, 2'b01, 0, 0, E_MEM_LD, 0, "ld_mem_cnt5");
      cyc(1, 1, 2'b01, 0, 0, E_IDLE, 0, "rst_mem");
      cyc(0, 0, 2'b01, 0, 0, E_IDLE, 0, "after_rst");

      for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (sb_q.size() != 0) begin
         n_errors++;
         $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
